// File: rtl/mux4way16_arbiter.sv
// Four-channel merge: round-robin arbitration with optional packet locking,
// feeding a registered output stage that can load and drain in one cycle.
module mux4way16_arbiter #(
  parameter int unsigned WIDTH      = 16,
  parameter bit          LOCK_BURST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             a_valid,
  input  logic             b_valid,
  input  logic             c_valid,
  input  logic             d_valid,
  input  logic             a_last,
  input  logic             b_last,
  input  logic             c_last,
  input  logic             d_last,
  output logic             a_ready,
  output logic             b_ready,
  output logic             c_ready,
  output logic             d_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             out_last,
  output logic [1:0]       out_sel,
  input  logic             out_ready
);
  localparam int unsigned NCH = 4;
  localparam int unsigned SW  = 2;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [SW-1:0]    rr_q, rr_d;
  logic [SW-1:0]    owner_q, owner_d;
  logic [WIDTH-1:0] out_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic [SW-1:0]    out_sel_q;

  logic [WIDTH-1:0] data_arr [NCH];
  logic [NCH-1:0]   valid_v;
  logic [NCH-1:0]   last_v;
  logic [NCH-1:0]   ready_v;
  logic [SW-1:0]    gnt_idx;
  logic [SW-1:0]    scan_idx;
  logic             gnt_ok;
  logic             load;
  logic             xfer;

  assign data_arr[0] = a;
  assign data_arr[1] = b;
  assign data_arr[2] = c;
  assign data_arr[3] = d;
  assign valid_v     = {d_valid, c_valid, b_valid, a_valid};
  assign last_v      = {d_last, c_last, b_last, a_last};
  assign load        = !out_valid_q || out_ready;
  assign xfer        = |ready_v;

  // Arbitration state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
    end
  end

  // Next state: lock on a non-last beat, release and advance rr on the last.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    if (xfer) begin
      if (state_q == IDLE) begin
        if (LOCK_BURST && !last_v[gnt_idx]) begin
          state_d = LOCKED;
          owner_d = gnt_idx;
        end else begin
          rr_d = gnt_idx + SW'(1);
        end
      end else if (last_v[gnt_idx]) begin
        state_d = IDLE;
        rr_d    = owner_q + SW'(1);
      end
    end
  end

  // Grant and ready: scan from rr in IDLE; only the owner may proceed when LOCKED.
  always_comb begin
    gnt_idx  = owner_q;
    gnt_ok   = 1'b0;
    scan_idx = rr_q;
    ready_v  = '0;
    if (state_q == LOCKED) begin
      gnt_ok = valid_v[owner_q];
    end else begin
      // Descending offset so the closest channel to rr is the final winner.
      for (int k = NCH - 1; k >= 0; k--) begin
        scan_idx = rr_q + SW'(k);
        if (valid_v[scan_idx]) begin
          gnt_idx = scan_idx;
          gnt_ok  = 1'b1;
        end
      end
    end
    if (load && gnt_ok && rst_n) ready_v[gnt_idx] = 1'b1;
  end

  // Output stage: capture on accept, clear valid when drained with nothing new.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else if (load) begin
      if (xfer) begin
        out_q       <= data_arr[gnt_idx];
        out_last_q  <= last_v[gnt_idx];
        out_sel_q   <= gnt_idx;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign a_ready   = ready_v[0];
  assign b_ready   = ready_v[1];
  assign c_ready   = ready_v[2];
  assign d_ready   = ready_v[3];
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux4way16_arbiter.sv
// Bench for mux4way16_arbiter: directed scenarios plus randomized traffic
// compared against a round-robin/lock reference model and a beat scoreboard.
module tb_mux4way16_arbiter;
  localparam int unsigned W = 16;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] din [4];
  logic         vin [4];
  logic         lin [4];
  logic         out_ready;

  logic         a_ready, b_ready, c_ready, d_ready;
  logic [W-1:0] out;
  logic         out_valid, out_last;
  logic [1:0]   out_sel;
  logic         a_ready0, b_ready0, c_ready0, d_ready0;
  logic [W-1:0] out0;
  logic         out_valid0, out_last0;
  logic [1:0]   out_sel0;
  logic [3:0]   rdy, rdy0;

  assign rdy  = {d_ready, c_ready, b_ready, a_ready};
  assign rdy0 = {d_ready0, c_ready0, b_ready0, a_ready0};

  mux4way16_arbiter #(.WIDTH(W), .LOCK_BURST(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .a(din[0]), .b(din[1]), .c(din[2]), .d(din[3]),
    .a_valid(vin[0]), .b_valid(vin[1]), .c_valid(vin[2]), .d_valid(vin[3]),
    .a_last(lin[0]), .b_last(lin[1]), .c_last(lin[2]), .d_last(lin[3]),
    .a_ready(a_ready), .b_ready(b_ready), .c_ready(c_ready), .d_ready(d_ready),
    .out(out), .out_valid(out_valid), .out_last(out_last), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  mux4way16_arbiter #(.WIDTH(W), .LOCK_BURST(1'b0)) u_dut_nolock (
    .clk(clk), .rst_n(rst_n),
    .a(din[0]), .b(din[1]), .c(din[2]), .d(din[3]),
    .a_valid(vin[0]), .b_valid(vin[1]), .c_valid(vin[2]), .d_valid(vin[3]),
    .a_last(lin[0]), .b_last(lin[1]), .c_last(lin[2]), .d_last(lin[3]),
    .a_ready(a_ready0), .b_ready(b_ready0), .c_ready(c_ready0), .d_ready(d_ready0),
    .out(out0), .out_valid(out_valid0), .out_last(out_last0), .out_sel(out_sel0),
    .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  // Reference model for the LOCK_BURST=1 instance (owner = -1 means unlocked).
  int           m_rr;
  int           m_owner;
  logic         m_ov;
  logic         m_last;
  logic [W-1:0] m_out;
  int           m_sel;
  logic [W+2:0] sb_q [$];

  task automatic model_reset();
    m_rr = 0; m_owner = -1; m_ov = 1'b0; m_last = 1'b0; m_out = '0; m_sel = 0;
    sb_q.delete();
  endtask

  function automatic int model_grant();
    if (!rst_n) return -1;
    if (m_ov && !out_ready) return -1;
    if (m_owner >= 0) return vin[m_owner] ? m_owner : -1;
    for (int k = 0; k < 4; k++) begin
      if (vin[(m_rr + k) % 4]) return (m_rr + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_rdy();
    int g;
    g = model_grant();
    return (g < 0) ? 4'b0000 : 4'(1 << g);
  endfunction

  // Advance one clock; the model consumes the inputs present before the edge.
  task automatic tick(output int g);
    bit ld;
    ld = !m_ov || out_ready;
    g  = model_grant();
    @(posedge clk);
    if (rst_n && ld) begin
      if (g >= 0) begin
        m_out = din[g]; m_last = lin[g]; m_sel = g; m_ov = 1'b1;
        sb_q.push_back({2'(g), lin[g], din[g]});
        if (m_owner < 0) begin
          if (!lin[g]) m_owner = g;
          else m_rr = (g + 1) % 4;
        end else if (lin[g]) begin
          m_owner = -1;
          m_rr = (g + 1) % 4;
        end
      end else begin
        m_ov = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 4; i++) begin
      vin[i] = 1'b0; lin[i] = 1'b0; din[i] = '0;
    end
  endtask

  task automatic reset_both();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vin[i] = 1'b1; lin[i] = 1'b1; din[i] = 16'hFFFF;
    end
    model_reset();
    #2;
    checks++; if (rdy !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", rdy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h expected 0000", out); end
    checks++; if (out_last !== 1'b0 || out_sel !== 2'd0) begin
      errors++; $display("FAIL reset_last_sel: got last=%b sel=%0d expected 0/0", out_last, out_sel);
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int g;
    vin[2] = 1'b1; din[2] = 16'h1234; lin[2] = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (rdy !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", rdy); end
    tick(g);
    vin[2] = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || out !== 16'h1234 || out_sel !== 2'd2 || out_last !== 1'b1) begin
      errors++; $display("FAIL single_out: got v=%b d=%h sel=%0d last=%b expected 1/1234/2/1", out_valid, out, out_sel, out_last);
    end
    tick(g);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_round_robin();
    int g;
    logic [W-1:0] exp_d;
    reset_both();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vin[i] = 1'b1; lin[i] = 1'b1; din[i] = 16'(32'hA000 + i * 32'h1000);
    end
    for (int i = 0; i < 9; i++) begin
      #1;
      checks++; if (rdy !== 4'(1 << (i % 4))) begin
        errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", i, rdy, 4'(1 << (i % 4)));
      end
      if (i > 0) begin
        exp_d = 16'(32'hA000 + ((i - 1) % 4) * 32'h1000);
        checks++; if (out_valid !== 1'b1 || out_sel !== 2'((i - 1) % 4) || out !== exp_d) begin
          errors++; $display("FAIL rr_out[%0d]: got v=%b sel=%0d d=%h expected 1/%0d/%h", i, out_valid, out_sel, out, (i - 1) % 4, exp_d);
        end
      end
      tick(g);
    end
    idle_inputs();
  endtask

  task automatic test_burst();
    int g;
    logic [3:0]   rdy_e [6];
    logic [1:0]   sel_e [6];
    logic [W-1:0] dat_e [6];
    logic         last_e [6];
    rdy_e  = '{4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0001, 4'b0000};
    sel_e  = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd3, 2'd0};
    dat_e  = '{16'h0AAA, 16'h0001, 16'h0002, 16'h0003, 16'hD00D, 16'hA00A};
    last_e = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    reset_both();
    out_ready = 1'b1;
    vin[0] = 1'b1; din[0] = 16'h0AAA; lin[0] = 1'b1;
    #1;
    checks++; if (rdy !== 4'b0001) begin errors++; $display("FAIL burst_prime: got %b expected 0001", rdy); end
    tick(g);
    din[0] = 16'hA00A;
    vin[3] = 1'b1; din[3] = 16'hD00D; lin[3] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      vin[1] = (k < 3);
      din[1] = (k < 3) ? 16'(k + 1) : 16'h0;
      lin[1] = (k == 2);
      if (k >= 4) vin[3] = 1'b0;
      if (k >= 5) vin[0] = 1'b0;
      #1;
      checks++; if (rdy !== rdy_e[k]) begin errors++; $display("FAIL burst_ready[%0d]: got %b expected %b", k, rdy, rdy_e[k]); end
      checks++; if (out_valid !== 1'b1 || out_sel !== sel_e[k] || out !== dat_e[k] || out_last !== last_e[k]) begin
        errors++; $display("FAIL burst_out[%0d]: got v=%b sel=%0d d=%h last=%b expected 1/%0d/%h/%b",
                           k, out_valid, out_sel, out, out_last, sel_e[k], dat_e[k], last_e[k]);
      end
      tick(g);
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    int g;
    int pops;
    logic [W-1:0] held;
    logic [W+2:0] beat;
    reset_both();
    pops = 0;
    held = '0;
    vin[0] = 1'b1; din[0] = 16'h5000; lin[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      out_ready = !(i >= 3 && i <= 6);
      vin[0] = (i < 10);
      #1;
      if (i == 3) held = out;
      checks++; if (rdy !== exp_rdy()) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected %b", i, rdy, exp_rdy()); end
      if (i >= 3 && i <= 6) begin
        checks++; if (rdy !== 4'b0000 || out_valid !== 1'b1 || out !== held) begin
          errors++; $display("FAIL bp_stall[%0d]: got rdy=%b v=%b d=%h expected 0000/1/%h", i, rdy, out_valid, out, held);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++; $display("FAIL bp_sb_extra[%0d]: got beat %h expected none", i, out);
        end else begin
          beat = sb_q.pop_front();
          pops++;
          if (out !== beat[W-1:0] || out_sel !== beat[W+2:W+1]) begin
            errors++; $display("FAIL bp_sb[%0d]: got %h/%0d expected %h/%0d", i, out, out_sel, beat[W-1:0], beat[W+2:W+1]);
          end
        end
      end
      tick(g);
      if (g == 0) din[0] = din[0] + 16'h1;
    end
    checks++; if (sb_q.size() != 0 || pops != int'(din[0] - 16'h5000)) begin
      errors++; $display("FAIL bp_count: got pops=%0d left=%0d expected pops=%0d left=0", pops, sb_q.size(), int'(din[0] - 16'h5000));
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    int g;
    reset_both();
    out_ready = 1'b1;
    vin[1] = 1'b1; din[1] = 16'h0B0B; lin[1] = 1'b1;
    #1;
    tick(g);
    vin[1] = 1'b0;
    vin[2] = 1'b1; din[2] = 16'h0C01; lin[2] = 1'b0;
    #1;
    checks++; if (rdy !== 4'b0100) begin errors++; $display("FAIL ar_c1: got %b expected 0100", rdy); end
    tick(g);
    din[2] = 16'h0C02;
    vin[0] = 1'b1; din[0] = 16'h0A01; lin[0] = 1'b1;
    #1;
    checks++; if (rdy !== 4'b0100) begin errors++; $display("FAIL ar_c2_locked: got %b expected 0100", rdy); end
    tick(g);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (out_valid !== 1'b0 || out !== 16'h0 || rdy !== 4'b0000) begin
      errors++; $display("FAIL ar_immediate: got v=%b d=%h rdy=%b expected 0/0000/0000", out_valid, out, rdy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    din[2] = 16'h0C01;
    #1;
    checks++; if (rdy !== 4'b0001) begin errors++; $display("FAIL ar_regrant: got %b expected 0001", rdy); end
    tick(g);
    vin[0] = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_sel !== 2'd0 || out !== 16'h0A01) begin
      errors++; $display("FAIL ar_out: got v=%b sel=%0d d=%h expected 1/0/0a01", out_valid, out_sel, out);
    end
    idle_inputs();
  endtask

  task automatic test_nolock();
    int g;
    reset_both();
    out_ready = 1'b1;
    vin[0] = 1'b1; din[0] = 16'h0A0A; lin[0] = 1'b0;
    vin[1] = 1'b1; din[1] = 16'h0B0B; lin[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (rdy0 !== ((i % 2 == 0) ? 4'b0001 : 4'b0010)) begin
        errors++; $display("FAIL nolock_ready[%0d]: got %b expected %b", i, rdy0, (i % 2 == 0) ? 4'b0001 : 4'b0010);
      end
      if (i > 0) begin
        checks++; if (out_valid0 !== 1'b1 || out_sel0 !== 2'((i - 1) % 2)) begin
          errors++; $display("FAIL nolock_sel[%0d]: got v=%b sel=%0d expected 1/%0d", i, out_valid0, out_sel0, (i - 1) % 2);
        end
      end
      checks++; if (rdy !== exp_rdy()) begin
        errors++; $display("FAIL lock_hold[%0d]: got %b expected %b", i, rdy, exp_rdy());
      end
      tick(g);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    int g;
    logic [W+2:0] beat;
    reset_both();
    g = -1;
    for (int n = 0; n < 400; n++) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (vin[ch] && g != ch && $urandom_range(0, 19) != 0) begin
          vin[ch] = 1'b1;
        end else begin
          vin[ch] = ($urandom_range(0, 99) < 55);
          din[ch] = 16'($urandom);
          lin[ch] = ($urandom_range(0, 2) == 0);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++; if (rdy !== exp_rdy()) begin errors++; $display("FAIL rnd_ready[%0d]: got %b expected %b", n, rdy, exp_rdy()); end
      checks++; if (out_valid !== m_ov) begin errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", n, out_valid, m_ov); end
      if (m_ov) begin
        checks++; if (out !== m_out || out_last !== m_last || out_sel !== 2'(m_sel)) begin
          errors++; $display("FAIL rnd_out[%0d]: got %h/%b/%0d expected %h/%b/%0d", n, out, out_last, out_sel, m_out, m_last, m_sel);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++; $display("FAIL rnd_sb_extra[%0d]: got beat %h expected none", n, out);
        end else begin
          beat = sb_q.pop_front();
          if (out !== beat[W-1:0] || out_last !== beat[W]) begin
            errors++; $display("FAIL rnd_sb[%0d]: got %h/%b expected %h/%b", n, out, out_last, beat[W-1:0], beat[W]);
          end
        end
      end
      tick(g);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    out_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_backpressure();
    test_async_reset();
    test_nolock();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
